// File: rtl/axi4lite_pkg.sv
// Shared response codes and channel FSM state types for the AXI4-Lite slave.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_WAIT_DATA = 2'd1,
    WR_WAIT_ADDR = 2'd2,
    WR_RESP      = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4lite_regfile.sv
// Word-indexed register file: slot 0 is the read-only ID word, the rest are RW.
// Slot 0 storage never leaves reset, so the exported image shows 0 there.
module axi4lite_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    IDX_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11E_0001
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   we_i,
  input  logic [IDX_WIDTH-1:0]                   wr_idx_i,
  input  logic [DATA_WIDTH-1:0]                  wr_data_i,
  input  logic [IDX_WIDTH-1:0]                   rd_idx_i,
  output logic [DATA_WIDTH-1:0]                  rd_data_o,
  output logic [(2**IDX_WIDTH)*DATA_WIDTH-1:0]   regs_o
);

  localparam int NUM_REGS = 2 ** IDX_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wr_idx_i != '0)) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (rd_idx_i == '0) ? ID_VALUE : regs_q[rd_idx_i];

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: rtl/axi4lite_slave.sv
// AXI4-Lite slave endpoint: independent write and read channel FSMs in front
// of a small register file whose contents are exported flat to the fabric.
module axi4lite_slave
  import axi4lite_pkg::*;
#(
  parameter int                    data_width    = 32,
  parameter int                    address_width = 6,
  parameter logic [data_width-1:0] ID_VALUE      = 32'hA11E_0001
) (
  input  logic                                          ACLK,
  input  logic                                          ARESET_N,
  input  logic [address_width-1:0]                      AWADDR,
  input  logic                                          AWVALID,
  output logic                                          AWREADY,
  input  logic [data_width-1:0]                         WDATA,
  input  logic                                          WVALID,
  output logic                                          WREADY,
  output logic [1:0]                                    BRESP,
  output logic                                          BVALID,
  input  logic                                          BREADY,
  input  logic [address_width-1:0]                      ARADDR,
  input  logic                                          ARVALID,
  output logic                                          ARREADY,
  output logic [data_width-1:0]                         RDATA,
  output logic [1:0]                                    RRESP,
  output logic                                          RVALID,
  input  logic                                          RREADY,
  output logic [(2**(address_width-2))*data_width-1:0]  regs_out,
  output logic                                          wr_strobe,
  output logic [address_width-3:0]                      wr_index
);

  localparam int IDX_W = address_width - 2;

  wr_state_t             wr_state_q;
  rd_state_t             rd_state_q;
  logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q, wr_strobe_q;
  logic [1:0]            bresp_q;
  logic [IDX_W-1:0]      awidx_q, wr_index_q;
  logic [data_width-1:0] wdata_q, rdata_q;

  logic                  commit_s, rw_commit_s;
  logic [IDX_W-1:0]      cmt_idx_s, rd_idx_s;
  logic [data_width-1:0] cmt_data_s, rd_data_s;
  logic                  addr_lsb_unused;

  assign addr_lsb_unused = ^{AWADDR[1:0], ARADDR[1:0]};
  assign rd_idx_s        = ARADDR[address_width-1:2];

  // The commit fires on the edge completing the last of the AW/W handshakes;
  // whichever half arrived earlier comes from its holding register.
  always_comb begin
    commit_s   = 1'b0;
    cmt_idx_s  = AWADDR[address_width-1:2];
    cmt_data_s = WDATA;
    case (wr_state_q)
      WR_IDLE: commit_s = AWVALID & awready_q & WVALID & wready_q;
      WR_WAIT_DATA: begin
        commit_s  = WVALID & wready_q;
        cmt_idx_s = awidx_q;
      end
      WR_WAIT_ADDR: begin
        commit_s   = AWVALID & awready_q;
        cmt_data_s = wdata_q;
      end
      default: commit_s = 1'b0;
    endcase
  end

  assign rw_commit_s = commit_s & (cmt_idx_s != '0);

  axi4lite_regfile #(
    .DATA_WIDTH (data_width),
    .IDX_WIDTH  (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk_i     (ACLK),
    .rst_ni    (ARESET_N),
    .we_i      (rw_commit_s),
    .wr_idx_i  (cmt_idx_s),
    .wr_data_i (cmt_data_s),
    .rd_idx_i  (rd_idx_s),
    .rd_data_o (rd_data_s),
    .regs_o    (regs_out)
  );

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      wr_state_q  <= WR_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      awidx_q     <= '0;
      wdata_q     <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (commit_s) begin
        wr_state_q  <= WR_RESP;
        awready_q   <= 1'b0;
        wready_q    <= 1'b0;
        bvalid_q    <= 1'b1;
        bresp_q     <= rw_commit_s ? RESP_OKAY : RESP_SLVERR;
        wr_strobe_q <= rw_commit_s;
        if (rw_commit_s) begin
          wr_index_q <= cmt_idx_s;
        end
      end else begin
        case (wr_state_q)
          WR_IDLE: begin
            if (AWVALID && awready_q) begin
              awidx_q    <= AWADDR[address_width-1:2];
              awready_q  <= 1'b0;
              wready_q   <= 1'b1;
              wr_state_q <= WR_WAIT_DATA;
            end else if (WVALID && wready_q) begin
              wdata_q    <= WDATA;
              awready_q  <= 1'b1;
              wready_q   <= 1'b0;
              wr_state_q <= WR_WAIT_ADDR;
            end else begin
              awready_q <= 1'b1;
              wready_q  <= 1'b1;
            end
          end
          WR_WAIT_DATA, WR_WAIT_ADDR: wr_state_q <= wr_state_q;
          WR_RESP: begin
            if (BREADY) begin
              bvalid_q   <= 1'b0;
              awready_q  <= 1'b1;
              wready_q   <= 1'b1;
              wr_state_q <= WR_IDLE;
            end
          end
          default: wr_state_q <= WR_IDLE;
        endcase
      end
    end
  end

  // Read data is captured from the pre-edge register value, so a same-edge
  // write to the same register is not visible until the next read.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ARVALID && arready_q) begin
            rdata_q    <= rd_data_s;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rd_state_q <= RD_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RD_DATA: begin
          if (RREADY) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = RESP_OKAY;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_axi4lite_slave.sv
// Directed plus randomized bench for axi4lite_slave against an array model.
module tb_axi4lite_slave;

  localparam logic [31:0] ID = 32'hA11E_0001;

  logic         ACLK = 1'b0;
  logic         ARESET_N = 1'b0;
  logic [5:0]   AWADDR = 6'h0, ARADDR = 6'h0;
  logic         AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0]  WDATA = 32'h0;
  logic         AWREADY, WREADY, BVALID, ARREADY, RVALID, wr_strobe;
  logic [1:0]   BRESP, RRESP;
  logic [31:0]  RDATA;
  logic [511:0] regs_out;
  logic [3:0]   wr_index;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [16];
  int          last_idx = 0;

  axi4lite_slave dut (
    .ACLK(ACLK), .ARESET_N(ARESET_N),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [5:0] addr);
    int idx;
    idx = int'(addr[5:2]);
    return (idx == 0) ? ID : model[idx];
  endfunction

  task automatic check_image();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("regs_out[%0d]", i), regs_out[i*32 +: 32], (i == 0) ? 32'h0 : model[i]);
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int idx = int'(addr[5:2]);
    logic [1:0] exp_resp;
    while (!(aw_done && w_done) && cyc < 64) begin
      if (aw_done && !w_done) begin
        check("awready_wait_data", AWREADY, 32'd0);
        check("wready_wait_data", WREADY, 32'd1);
      end else if (w_done && !aw_done) begin
        check("awready_wait_addr", AWREADY, 32'd1);
        check("wready_wait_addr", WREADY, 32'd0);
      end
      AWADDR  = addr;
      WDATA   = data;
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      hs_aw   = AWVALID && AWREADY;
      hs_w    = WVALID && WREADY;
      @(negedge ACLK);
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      cyc++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("aw_w_handshake_done", {31'd0, aw_done && w_done}, 32'd1);
    exp_resp = (idx == 0) ? 2'b10 : 2'b00;
    if (idx != 0) begin
      model[idx] = data;
      last_idx = idx;
    end
    check("bvalid_after_commit", BVALID, 32'd1);
    check("bresp", BRESP, exp_resp);
    check("wr_strobe_pulse", wr_strobe, (idx != 0) ? 32'd1 : 32'd0);
    check("wr_index", wr_index, last_idx);
    for (int k = 0; k < b_dly; k++) begin
      @(negedge ACLK);
      check("bvalid_hold", BVALID, 32'd1);
      check("bresp_hold", BRESP, exp_resp);
      check("awready_in_resp", AWREADY, 32'd0);
      check("wready_in_resp", WREADY, 32'd0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("bvalid_cleared", BVALID, 32'd0);
    check("wr_strobe_one_cycle", wr_strobe, 32'd0);
    check("awready_after_b", AWREADY, 32'd1);
    check("wready_after_b", WREADY, 32'd1);
    check_image();
  endtask

  task automatic do_read(input logic [5:0] addr, input int r_dly);
    int cyc = 0;
    bit hs = 0;
    logic [31:0] exp = ref_read(addr);
    ARADDR  = addr;
    ARVALID = 1'b1;
    while (!hs && cyc < 64) begin
      hs = ARREADY;
      @(negedge ACLK);
      cyc++;
    end
    ARVALID = 1'b0;
    check("ar_handshake_done", {31'd0, hs}, 32'd1);
    check("rvalid", RVALID, 32'd1);
    check("rresp", RRESP, 32'd0);
    check($sformatf("rdata@%h", addr), RDATA, exp);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge ACLK);
      check("rvalid_hold", RVALID, 32'd1);
      check("rdata_hold", RDATA, exp);
      check("arready_in_data", ARREADY, 32'd0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("rvalid_cleared", RVALID, 32'd0);
    check("arready_after_r", ARREADY, 32'd1);
  endtask

  task automatic check_all_zero(input string phase);
    check({phase, "_awready"}, AWREADY, 32'd0);
    check({phase, "_wready"}, WREADY, 32'd0);
    check({phase, "_bvalid"}, BVALID, 32'd0);
    check({phase, "_bresp"}, BRESP, 32'd0);
    check({phase, "_arready"}, ARREADY, 32'd0);
    check({phase, "_rvalid"}, RVALID, 32'd0);
    check({phase, "_rdata"}, RDATA, 32'd0);
    check({phase, "_rresp"}, RRESP, 32'd0);
    check({phase, "_wr_strobe"}, wr_strobe, 32'd0);
    check({phase, "_wr_index"}, wr_index, 32'd0);
    check_image();
  endtask

  initial begin
    logic [5:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state and ready rise on the first edge after release
    repeat (2) @(negedge ACLK);
    check_all_zero("reset");
    ARESET_N = 1'b1;
    check("awready_before_first_edge", AWREADY, 32'd0);
    @(negedge ACLK);
    check("awready_first_edge", AWREADY, 32'd1);
    check("wready_first_edge", WREADY, 32'd1);
    check("arready_first_edge", ARREADY, 32'd1);

    // 1: AW and W together
    do_write(6'h04, 32'hDEAD_BEEF, 0, 0, 0);
    check("regs_out_63_32", regs_out[63:32], 32'hDEAD_BEEF);
    // 2: W three cycles after AW
    do_write(6'h08, 32'h0000_1234, 0, 3, 0);
    do_read(6'h08, 0);
    // 3: W before AW to the ID register
    do_write(6'h00, 32'h5555_AAAA, 2, 0, 1);
    do_read(6'h00, 0);
    // 4: BREADY withheld for 5 cycles
    do_write(6'h14, 32'hCAFE_F00D, 0, 0, 5);
    do_read(6'h14, 2);

    // 5: same-edge write and read of register 3
    do_write(6'h0C, 32'h0000_0005, 0, 0, 0);
    AWADDR = 6'h0C; WDATA = 32'h0000_0009; ARADDR = 6'h0C;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("coll_bvalid", BVALID, 32'd1);
    check("coll_rvalid", RVALID, 32'd1);
    check("coll_rdata_old", RDATA, 32'h0000_0005);
    model[3] = 32'h0000_0009;
    last_idx = 3;
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    check("coll_bvalid_cleared", BVALID, 32'd0);
    check("coll_rvalid_cleared", RVALID, 32'd0);
    do_read(6'h0C, 0);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      a = 6'($urandom_range(0, 63));
      do_read(a, $urandom_range(0, 2));
    end

    // 6: reset while waiting for write data
    AWADDR = 6'h10; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("wait_data_awready", AWREADY, 32'd0);
    check("wait_data_wready", WREADY, 32'd1);
    #2 ARESET_N = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    last_idx = 0;
    #1 check_all_zero("midreset");
    @(negedge ACLK);
    ARESET_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      check("no_bvalid_after_reset", BVALID, 32'd0);
    end
    do_read(6'h00, 0);
    do_read(6'h10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave.md
Name: axi4lite_slave

Overview:
AXI4-Lite slave endpoint that terminates the five channels driven by the team's AXI4-Lite master and maps them onto a small word-addressed register file. It sits directly downstream of the master on the same ACLK domain. Register contents are exported flat to fabric logic, together with a one-cycle write-commit strobe. Register 0 is a read-only ID word.

Parameters:
data_width, 32, width of WDATA/RDATA and of each register
address_width, 6, byte address width; NUM_REGS = 2**(address_width-2) (16 at default)
ID_VALUE, 32'hA11E_0001, constant returned by register 0

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESET_N  input  1  asynchronous active-low reset
AWADDR  input  address_width  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  data_width  write data
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BRESP  output  2  write response
BVALID  output  1  write response valid
BREADY  input  1  write response ready
ARADDR  input  address_width  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  data_width  read data
RRESP  output  2  read response, always OKAY
RVALID  output  1  read data valid
RREADY  input  1  read data ready
regs_out  output  NUM_REGS*data_width  flat register image; reg i at bits [i*data_width +: data_width]
wr_strobe  output  1  one-cycle pulse on write commit to a RW register
wr_index  output  address_width-2  index of the last committed write

Behaviour:
- Reset (ARESET_N low, asynchronous): all outputs 0, RW regs 0, both FSMs idle. The ready flops rise on the first ACLK edge after deassertion.
- Register index = addr[address_width-1:2]; addr[1:0] ignored. Reg 0 reads ID_VALUE. Regs 1..NUM_REGS-1 are RW.
- Write FSM, registered outputs:
  - WR_IDLE (AWREADY=1, WREADY=1):
    - AWVALID&WVALID -> commit, go to WR_RESP.
    - AWVALID only -> latch addr, go to WR_WAIT_DATA.
    - WVALID only -> latch data, go to WR_WAIT_ADDR.
  - WR_WAIT_DATA (AWREADY=0, WREADY=1): WVALID -> commit, go to WR_RESP.
  - WR_WAIT_ADDR (AWREADY=1, WREADY=0): AWVALID -> commit, go to WR_RESP.
  - WR_RESP (both readys 0, BVALID=1): BRESP and BVALID stay stable until BREADY is sampled high, then go to WR_IDLE with BVALID=0 next cycle.
- Commit happens on the edge of the last AW/W handshake:
  - RW target: register updated; wr_strobe=1 and wr_index=index in the following cycle; BRESP=OKAY (2'b00).
  - Target reg 0: no update, no strobe, BRESP=SLVERR (2'b10).
  - BVALID is high 1 cycle after commit.
- Read FSM:
  - RD_IDLE (ARREADY=1): on ARVALID, RDATA is loaded from the register value before this edge's write, RRESP=OKAY, go to RD_DATA.
  - RD_DATA (ARREADY=0, RVALID=1): RDATA held stable until RREADY is sampled, then go to RD_IDLE.
  - Latency: RVALID 1 cycle after the AR handshake. Minimum 3 cycles per read.
- Simultaneous read and write to the same register on the same edge: the read returns the old value; a subsequent read returns the new value.
- Read and write FSMs are fully independent; no ordering between channels.
- BVALID and RVALID never deassert without the matching READY. The master asserts BREADY/RREADY a cycle after seeing VALID; this must work.
- Reset mid-transaction: the transaction is discarded, registers clear, no response is issued.

Decomposition:
- Package axi4lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, enum wr_state_t {WR_IDLE, WR_WAIT_DATA, WR_WAIT_ADDR, WR_RESP}, enum rd_state_t {RD_IDLE, RD_DATA}.
- One sub-module, axi4lite_regfile:
  - storage, ID mux and flat export;
  - write port (we, index, data) and combinational read port (index -> data).
- The top level holds both channel FSMs.

Test Plan:
1. AW and W same cycle, addr 6'h04, data 32'hDEAD_BEEF -> BVALID 1 cycle later with BRESP=00; wr_strobe pulse with wr_index=1; regs_out[63:32]=DEAD_BEEF.
2. AW at cycle 0, W at cycle 3 (addr 6'h08, data 32'h1234) -> AWREADY low during cycles 1-3; commit at cycle 3; BVALID cycle 4; then read of 6'h08 returns 32'h1234.
3. W before AW to addr 6'h00 -> BRESP=10; no wr_strobe; read of 6'h00 returns 32'hA11E_0001.
4. BREADY held low 5 cycles -> BVALID and BRESP stable throughout; AWREADY/WREADY stay 0 until 1 cycle after BREADY.
5. Reg 3 holds 32'h5; write 32'h9 to reg 3 and read reg 3 handshake on the same edge -> RDATA=32'h5; the next read returns 32'h9.
6. Assert ARESET_N low while in WR_WAIT_DATA -> all outputs 0 immediately; no BVALID after release; regs_out returns to 0 apart from the ID read path.
